// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell, one borrow flop.
// Produces diff = a - b LSB first over WIDTH cycles.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ser_d,
  output logic             ser_valid
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_bn;
  logic [WIDTH-1:0] w_shadow_nx;

  assign w_x = r_sa[0];
  assign w_y = r_sb[0];
  assign w_d = w_x ^ w_y ^ r_borrow;
  assign w_bn = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
  assign w_shadow_nx = {w_d, r_shadow[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_shadow <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa     <= a;
            r_sb     <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          r_sa     <= r_sa >> 1;
          r_sb     <= r_sb >> 1;
          r_shadow <= w_shadow_nx;
          r_borrow <= w_bn;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_diff <= w_shadow_nx;
            r_bout <= w_bn;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    ser_valid = (r_state == S_SHIFT);
    ser_d     = w_d;
    diff      = r_diff;
    bout      = r_bout;
  end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Bench for serial_full_subtractor: 8-bit directed scenarios
// plus an exhaustive 4-bit sweep on a second instance.
module tb_serial_full_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ser_d;
  logic       ser_valid;

  logic       s4_start;
  logic [3:0] s4_a;
  logic [3:0] s4_b;
  logic       s4_busy;
  logic       s4_done;
  logic [3:0] s4_diff;
  logic       s4_bout;
  logic       s4_ser_d;
  logic       s4_ser_valid;

  int total = 0;
  int bad = 0;

  logic [8:0] sb[$];
  logic [4:0] sb4[$];

  always #5 clk = ~clk;

  serial_full_subtractor #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .diff(diff), .bout(bout),
    .ser_d(ser_d), .ser_valid(ser_valid)
  );

  serial_full_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(s4_start),
    .a(s4_a), .b(s4_b), .busy(s4_busy),
    .done(s4_done), .diff(s4_diff),
    .bout(s4_bout), .ser_d(s4_ser_d),
    .ser_valid(s4_ser_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    s4_start = 1'b1;
    s4_a = 4'h1;
    s4_b = 4'h2;
    tick();
    tick();
    total++;
    if ({busy, done, ser_valid, bout, diff} !== 12'h000) begin
      bad++;
      $display("FAIL reset: got b=%b d=%b v=%b bo=%b diff=%h req 0",
               busy, done, ser_valid, bout, diff);
    end
    total++;
    if ({s4_busy, s4_done, s4_bout, s4_diff} !== 7'h00) begin
      bad++;
      $display("FAIL reset4: got busy=%b done=%b diff=%h req 0",
               s4_busy, s4_done, s4_diff);
    end
    rst = 1'b0;
    start = 1'b0;
    s4_start = 1'b0;
    tick();
  endtask

  task automatic test_vectors;
    logic [7:0] ta[5] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h00};
    logic [7:0] tb[5] = '{8'h03, 8'h05, 8'hFF, 8'h01, 8'h00};
    logic [8:0] e;
    logic [8:0] got;
    for (int i = 0; i < 5; i++) begin
      e = {1'b0, ta[i]} - {1'b0, tb[i]};
      sb.push_back(e);
      a = ta[i];
      b = tb[i];
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < 8; j++) begin
        total++;
        if (ser_valid !== 1'b1 || ser_d !== e[j] || done !== 1'b0) begin
          bad++;
          $display("FAIL serial v%0d bit%0d: got v=%b d=%b dn=%b req v=1 d=%b dn=0",
                   i, j, ser_valid, ser_d, done, e[j]);
        end
        tick();
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b1 || ser_valid !== 1'b0) begin
        bad++;
        $display("FAIL latency v%0d: got done=%b busy=%b v=%b req 1 1 0",
                 i, done, busy, ser_valid);
      end
      got = {bout, diff};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL result v%0d: got bout=%b diff=%h req bout=%b diff=%h",
                 i, got[8], got[7:0], e[8], e[7:0]);
      end
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL idle v%0d: got busy=%b done=%b req 0 0",
                 i, busy, done);
      end
    end
  endtask

  task automatic test_sweep4;
    logic [4:0] e;
    logic [4:0] got;
    int cyc;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        e = {1'b0, 4'(x)} - {1'b0, 4'(y)};
        sb4.push_back(e);
        s4_a = 4'(x);
        s4_b = 4'(y);
        s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        cyc = 0;
        while (s4_done !== 1'b1 && cyc < 20) begin
          tick();
          cyc++;
        end
        e = sb4.pop_front();
        got = {s4_bout, s4_diff};
        total++;
        if (cyc != 4 || got !== e) begin
          bad++;
          $display("FAIL sweep4 %0d-%0d: got cyc=%0d bout=%b diff=%h req cyc=4 bout=%b diff=%h",
                   x, y, cyc, got[4], got[3:0], e[4], e[3:0]);
        end
        tick();
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [8:0] e;
    logic [8:0] got;
    int busyc;
    int donec;
    e = {1'b0, 8'h10} - {1'b0, 8'h01};
    sb.push_back(e);
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    busyc = 0;
    donec = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) begin
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy === 1'b1) busyc++;
      if (done === 1'b1) begin
        donec++;
        got = {bout, diff};
        e = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL ignore result: got bout=%b diff=%h req bout=%b diff=%h",
                   got[8], got[7:0], e[8], e[7:0]);
        end
      end
      tick();
    end
    start = 1'b0;
    total++;
    if (busyc != 9 || donec != 1) begin
      bad++;
      $display("FAIL ignore count: got busy=%0d done=%0d req busy=9 done=1",
               busyc, donec);
    end
  endtask

  task automatic test_reset_abort;
    logic [8:0] e;
    logic [8:0] got;
    int donec;
    int cyc;
    a = 8'h80;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, done, ser_valid, bout, diff} !== 12'h000) begin
      bad++;
      $display("FAIL abort: got busy=%b done=%b v=%b bout=%b diff=%h req 0",
               busy, done, ser_valid, bout, diff);
    end
    donec = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) donec++;
      tick();
    end
    total++;
    if (donec != 0) begin
      bad++;
      $display("FAIL abort done: got %0d pulses req 0", donec);
    end
    e = {1'b0, 8'h80} - {1'b0, 8'h01};
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    got = {bout, diff};
    e = sb.pop_front();
    total++;
    if (cyc != 8 || got !== e) begin
      bad++;
      $display("FAIL after abort: got cyc=%0d bout=%b diff=%h req cyc=8 bout=%b diff=%h",
               cyc, got[8], got[7:0], e[8], e[7:0]);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [8:0] e;
    int cyc;
    int last;
    int pulses;
    e = {1'b0, 8'h09} - {1'b0, 8'h04};
    a = 8'h09;
    b = 8'h04;
    start = 1'b1;
    last = -1;
    pulses = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (done === 1'b1) begin
        pulses++;
        total++;
        if ({bout, diff} !== e || (last >= 0 && cyc - last != 10)) begin
          bad++;
          $display("FAIL b2b pulse %0d: got diff=%h bout=%b gap=%0d req diff=%h bout=%b gap=10",
                   pulses, diff, bout, cyc - last, e[7:0], e[8]);
        end
        last = cyc;
      end else if (pulses > 0) begin
        total++;
        if ({bout, diff} !== e) begin
          bad++;
          $display("FAIL b2b stable cyc %0d: got diff=%h req %h",
                   cyc, diff, e[7:0]);
        end
      end
    end
    start = 1'b0;
    total++;
    if (pulses != 4) begin
      bad++;
      $display("FAIL b2b pulses: got %0d req 4", pulses);
    end
    for (int c = 0; c < 12; c++) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout req finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    s4_start = 1'b0;
    s4_a = '0;
    s4_b = '0;
    #1;
    test_reset();
    test_vectors();
    test_sweep4();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
